fb_write_ctrl: RTL and testbench

FB_WRITE_CTRL -- requirements
Module: fb_write_ctrl

---
 rtl/fb_write_ctrl_if.sv | 30 +++
 rtl/fb_write_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_fb_write_ctrl.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_write_ctrl_if.sv
// Frame-buffer write controller bus: host write port, clear/background
// requests and the registered frame-buffer write port.
interface fb_write_ctrl_if;
    logic        host_req;
    logic [12:0] host_addr;
    logic [1:0]  host_colour;
    logic        host_ack;
    logic        host_err;
    logic        clr_req;
    logic [1:0]  clr_colour;
    logic        clr_done;
    logic        bg_req;
    logic [23:0] bg_colour;
    logic [12:0] fb_addr;
    logic [1:0]  fb_colour;
    logic        fb_ie;
    logic        busy;

    modport master (
        output host_req, host_addr, host_colour, clr_req, clr_colour,
               bg_req, bg_colour,
        input  host_ack, host_err, clr_done, fb_addr, fb_colour, fb_ie, busy
    );

    modport slave (
        input  host_req, host_addr, host_colour, clr_req, clr_colour,
               bg_req, bg_colour,
        output host_ack, host_err, clr_done, fb_addr, fb_colour, fb_ie, busy
    );
endinterface

// File: rtl/fb_write_ctrl.sv
// Frame-buffer write controller. Arbitrates host pixel writes against a
// full-screen clear sweep and a 12-cell background-colour burst. Every
// frame-buffer write is decided one cycle and presented registered the next.
module fb_write_ctrl #(
    parameter logic [12:0] BG_BASE  = 13'h1FF4,
    parameter logic [12:0] CLR_LAST = 13'h1FF3
) (
    input  logic           clk,
    input  logic           rst,
    fb_write_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_BG    = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [12:0] ptr_q, ptr_d;
    logic [3:0]  bg_k_q, bg_k_d;
    logic        bg_pend_q, bg_pend_d;
    logic        clr_pend_q, clr_pend_d;
    logic [23:0] bg_next_q, bg_next_d;
    logic [23:0] bg_cur_q, bg_cur_d;
    logic [1:0]  clr_next_q, clr_next_d;
    logic [1:0]  clr_cur_q, clr_cur_d;
    logic [12:0] fb_addr_q, fb_addr_d;
    logic [1:0]  fb_colour_q, fb_colour_d;
    logic        fb_ie_q, fb_ie_d;
    logic        host_ack_q, host_ack_d;
    logic        host_err_q, host_err_d;
    logic        clr_done_q, clr_done_d;
    logic        busy_q, busy_d;
    logic        grant_s;

    // Background cell k carries the colour's bytes high-to-low, each byte
    // sent as four 2-bit fields starting from its least significant pair.
    function automatic logic [1:0] bg_slice(input logic [23:0] c, input logic [3:0] k);
        logic [1:0] r;
        case (k)
            4'd0:    r = c[17:16];
            4'd1:    r = c[19:18];
            4'd2:    r = c[21:20];
            4'd3:    r = c[23:22];
            4'd4:    r = c[9:8];
            4'd5:    r = c[11:10];
            4'd6:    r = c[13:12];
            4'd7:    r = c[15:14];
            4'd8:    r = c[1:0];
            4'd9:    r = c[3:2];
            4'd10:   r = c[5:4];
            4'd11:   r = c[7:6];
            default: r = 2'b00;
        endcase
        return r;
    endfunction

    // The host owns the next write slot outside BG, at most every other cycle.
    assign grant_s = bus.host_req && !host_ack_q && (state_q != ST_BG);

    // Next-state, write-slot selection and pending-request bookkeeping.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        bg_k_d      = bg_k_q;
        bg_pend_d   = bg_pend_q;
        clr_pend_d  = clr_pend_q;
        bg_next_d   = bg_next_q;
        bg_cur_d    = bg_cur_q;
        clr_next_d  = clr_next_q;
        clr_cur_d   = clr_cur_q;
        fb_addr_d   = fb_addr_q;
        fb_colour_d = fb_colour_q;
        fb_ie_d     = 1'b1;
        host_ack_d  = 1'b0;
        host_err_d  = 1'b0;
        clr_done_d  = 1'b0;

        if (grant_s) begin
            host_ack_d = 1'b1;
            if (bus.host_addr >= BG_BASE) begin
                host_err_d = 1'b1;
            end else begin
                fb_ie_d     = 1'b0;
                fb_addr_d   = bus.host_addr;
                fb_colour_d = bus.host_colour;
            end
        end else begin
            host_ack_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (bg_pend_q) begin
                    state_d   = ST_BG;
                    bg_k_d    = 4'd0;
                    bg_cur_d  = bg_next_q;
                    bg_pend_d = 1'b0;
                end else if (clr_pend_q) begin
                    state_d    = ST_CLEAR;
                    ptr_d      = 13'd0;
                    clr_cur_d  = clr_next_q;
                    clr_pend_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                // A host write takes this slot; the sweep pointer waits.
                if (!grant_s) begin
                    fb_ie_d     = 1'b0;
                    fb_addr_d   = ptr_q;
                    fb_colour_d = clr_cur_q;
                    if (ptr_q == CLR_LAST) begin
                        state_d    = ST_IDLE;
                        ptr_d      = 13'd0;
                        clr_done_d = 1'b1;
                    end else begin
                        ptr_d = ptr_q + 13'd1;
                    end
                end else begin
                    ptr_d = ptr_q;
                end
            end
            ST_BG: begin
                fb_ie_d     = 1'b0;
                fb_addr_d   = BG_BASE + {9'd0, bg_k_q};
                fb_colour_d = bg_slice(bg_cur_q, bg_k_q);
                if (bg_k_q == 4'd11) begin
                    state_d = ST_IDLE;
                    bg_k_d  = 4'd0;
                end else begin
                    bg_k_d = bg_k_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // New requests are latched after the IDLE consumption so a request
        // arriving on the start cycle stays pending for the next run.
        if (bus.bg_req) begin
            bg_pend_d = 1'b1;
            bg_next_d = bus.bg_colour;
        end else begin
            bg_next_d = bg_next_d;
        end
        if (bus.clr_req && (state_q != ST_CLEAR)) begin
            clr_pend_d = 1'b1;
            clr_next_d = bus.clr_colour;
        end else begin
            clr_next_d = clr_next_d;
        end

        busy_d = (state_d != ST_IDLE) || bg_pend_d || clr_pend_d;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 13'd0;
            bg_k_q      <= 4'd0;
            bg_pend_q   <= 1'b0;
            clr_pend_q  <= 1'b0;
            bg_next_q   <= 24'd0;
            bg_cur_q    <= 24'd0;
            clr_next_q  <= 2'd0;
            clr_cur_q   <= 2'd0;
            fb_addr_q   <= 13'd0;
            fb_colour_q <= 2'd0;
            fb_ie_q     <= 1'b1;
            host_ack_q  <= 1'b0;
            host_err_q  <= 1'b0;
            clr_done_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            bg_k_q      <= bg_k_d;
            bg_pend_q   <= bg_pend_d;
            clr_pend_q  <= clr_pend_d;
            bg_next_q   <= bg_next_d;
            bg_cur_q    <= bg_cur_d;
            clr_next_q  <= clr_next_d;
            clr_cur_q   <= clr_cur_d;
            fb_addr_q   <= fb_addr_d;
            fb_colour_q <= fb_colour_d;
            fb_ie_q     <= fb_ie_d;
            host_ack_q  <= host_ack_d;
            host_err_q  <= host_err_d;
            clr_done_q  <= clr_done_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.fb_addr   = fb_addr_q;
    assign bus.fb_colour = fb_colour_q;
    assign bus.fb_ie     = fb_ie_q;
    assign bus.host_ack  = host_ack_q;
    assign bus.host_err  = host_err_q;
    assign bus.clr_done  = clr_done_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_fb_write_ctrl.sv
// Bench for fb_write_ctrl: directed scenarios plus randomized traffic, all
// outputs checked every cycle against a job-level reference model.
module tb_fb_write_ctrl;
    localparam logic [12:0] BG_BASE  = 13'h1FF4;
    localparam logic [12:0] CLR_LAST = 13'h1FF3;
    localparam int J_IDLE = 0, J_CLEAR = 1, J_BG = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fb_write_ctrl_if bus();
    fb_write_ctrl #(.BG_BASE(BG_BASE), .CLR_LAST(CLR_LAST)) dut (
        .clk(clk), .rst(rst), .bus(bus));

    int vectors = 0;
    int miscompares = 0;

    // ---------------- reference model ----------------
    int          m_job = J_IDLE, m_ptr = 0, m_k = 0;
    logic        m_bgp = 1'b0, m_clrp = 1'b0;
    logic [23:0] m_bgn = '0, m_bg = '0;
    logic [1:0]  m_clrn = '0, m_clr = '0;
    logic        e_ie = 1'b1, e_ack = 1'b0, e_err = 1'b0, e_done = 1'b0, e_busy = 1'b0;
    logic [12:0] e_addr = '0;
    logic [1:0]  e_col = '0;

    function automatic logic [1:0] bg_field(input logic [23:0] c, input int k);
        int sh;
        sh = (2 - k / 4) * 8 + 2 * (k % 4);
        return 2'((c >> sh) & 24'd3);
    endfunction

    // Predict the registered outputs of the coming cycle from the job rules.
    always @(posedge clk) begin : model
        int job, ptr, k, job0;
        logic bgp, clrp, grant, ie, ack, err, done;
        logic [23:0] bgn, bgc;
        logic [1:0] clrn, clrc, col;
        logic [12:0] addr;
        if (rst) begin
            m_job <= J_IDLE; m_ptr <= 0; m_k <= 0; m_bgp <= 1'b0; m_clrp <= 1'b0;
            m_bgn <= '0; m_bg <= '0; m_clrn <= '0; m_clr <= '0;
            e_ie <= 1'b1; e_ack <= 1'b0; e_err <= 1'b0; e_done <= 1'b0;
            e_busy <= 1'b0; e_addr <= '0; e_col <= '0;
        end else begin
            job = m_job; ptr = m_ptr; k = m_k; bgp = m_bgp; clrp = m_clrp;
            bgn = m_bgn; bgc = m_bg; clrn = m_clrn; clrc = m_clr;
            addr = e_addr; col = e_col; job0 = job;
            grant = bus.host_req && !e_ack && (job != J_BG);
            ack = grant; err = 1'b0; ie = 1'b1; done = 1'b0;
            if (grant) begin
                if (bus.host_addr >= BG_BASE) err = 1'b1;
                else begin ie = 1'b0; addr = bus.host_addr; col = bus.host_colour; end
            end
            if (job == J_IDLE) begin
                if (bgp) begin job = J_BG; k = 0; bgc = bgn; bgp = 1'b0; end
                else if (clrp) begin job = J_CLEAR; ptr = 0; clrc = clrn; clrp = 1'b0; end
            end else if (job == J_CLEAR) begin
                if (!grant) begin
                    ie = 1'b0; addr = 13'(ptr); col = clrc;
                    if (ptr == int'(CLR_LAST)) begin job = J_IDLE; done = 1'b1; end
                    else ptr = ptr + 1;
                end
            end else begin
                ie = 1'b0; addr = 13'(int'(BG_BASE) + k); col = bg_field(bgc, k);
                if (k == 11) job = J_IDLE; else k = k + 1;
            end
            if (bus.bg_req) begin bgp = 1'b1; bgn = bus.bg_colour; end
            if (bus.clr_req && job0 != J_CLEAR) begin clrp = 1'b1; clrn = bus.clr_colour; end
            m_job <= job; m_ptr <= ptr; m_k <= k; m_bgp <= bgp; m_clrp <= clrp;
            m_bgn <= bgn; m_bg <= bgc; m_clrn <= clrn; m_clr <= clrc;
            e_ie <= ie; e_ack <= ack; e_err <= err; e_done <= done;
            e_addr <= addr; e_col <= col;
            e_busy <= (job != J_IDLE) || bgp || clrp;
        end
    end

    // ---------------- checking and bookkeeping ----------------
    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            if (miscompares <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    int n_wr = 0, n_ack = 0, n_err = 0, n_done = 0, n_h100 = 0;
    int n_col[4] = '{0, 0, 0, 0};
    logic [12:0] last_addr = '0;
    logic [14:0] bgq[$];

    int host_left = 0;
    logic host_fixed = 1'b0;
    logic [12:0] host_faddr = '0;
    logic [1:0] host_fcol = '0;

    task automatic tick();
        @(negedge clk);
        chk("fb_ie", 32'(bus.fb_ie), 32'(e_ie));
        chk("host_ack", 32'(bus.host_ack), 32'(e_ack));
        chk("host_err", 32'(bus.host_err), 32'(e_err));
        chk("clr_done", 32'(bus.clr_done), 32'(e_done));
        chk("busy", 32'(bus.busy), 32'(e_busy));
        if (!e_ie) begin
            chk("fb_addr", 32'(bus.fb_addr), 32'(e_addr));
            chk("fb_colour", 32'(bus.fb_colour), 32'(e_col));
        end
        if (!bus.fb_ie) begin
            n_wr++; n_col[bus.fb_colour]++; last_addr = bus.fb_addr;
            if (bus.fb_addr >= BG_BASE) bgq.push_back({bus.fb_addr, bus.fb_colour});
            if (bus.fb_addr == 13'h0100 && bus.fb_colour == 2'd1) n_h100++;
        end
        if (bus.host_ack) n_ack++;
        if (bus.host_err) n_err++;
        if (bus.clr_done) n_done++;
        // host agent: hold the request until acknowledged
        if (bus.host_req && bus.host_ack) bus.host_req = 1'b0;
        if (!bus.host_req && host_left > 0 && (host_fixed || $urandom_range(0, 2) == 0)) begin
            host_left--;
            bus.host_req = 1'b1;
            if (host_fixed) begin
                bus.host_addr = host_faddr; bus.host_colour = host_fcol;
            end else begin
                bus.host_addr = ($urandom_range(0, 3) == 0) ? 13'(int'(BG_BASE) + $urandom_range(0, 11))
                                                            : 13'($urandom_range(0, 8179));
                bus.host_colour = 2'($urandom());
            end
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_bg(input logic [23:0] c);
        bus.bg_req = 1'b1; bus.bg_colour = c; tick(); bus.bg_req = 1'b0;
    endtask

    task automatic pulse_clr(input logic [1:0] c);
        bus.clr_req = 1'b1; bus.clr_colour = c; tick(); bus.clr_req = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int d0, c;
        d0 = n_done; c = 0;
        while (n_done == d0 && c < budget) begin tick(); c++; end
        chk(name, 32'(n_done != d0), 32'd1);
    endtask

    int exp_a5[12] = '{1, 1, 2, 2, 3, 0, 0, 3, 0, 0, 3, 3};
    int exp_44[12] = '{0, 1, 0, 1, 1, 1, 1, 1, 2, 1, 2, 1};

    initial begin
        int q0, w0, a0, e0, d0, c0, h0, c;
        bus.host_req = 1'b0; bus.host_addr = '0; bus.host_colour = '0;
        bus.clr_req = 1'b0; bus.clr_colour = '0; bus.bg_req = 1'b0; bus.bg_colour = '0;

        // model pinned against hand-derived background fields
        for (int i = 0; i < 12; i++) chk("model_bg_field", 32'(bg_field(24'hA5C3F0, i)), 32'(exp_a5[i]));

        ticks(3);
        rst = 1'b0;
        chk("rst_fb_ie", 32'(bus.fb_ie), 32'd1);
        chk("rst_fb_addr", 32'(bus.fb_addr), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_ack", 32'(bus.host_ack), 32'd0);

        // background burst from IDLE
        q0 = bgq.size();
        pulse_bg(24'hA5C3F0);
        ticks(20);
        chk("bg_count", 32'(bgq.size() - q0), 32'd12);
        for (int i = 0; i < 12 && q0 + i < bgq.size(); i++) begin
            chk("bg_addr", 32'(bgq[q0 + i][14:2]), 32'(int'(BG_BASE) + i));
            chk("bg_data", 32'(bgq[q0 + i][1:0]), 32'(exp_a5[i]));
        end
        chk("bg_busy_after", 32'(bus.busy), 32'd0);

        // plain clear
        q0 = bgq.size(); w0 = n_wr; c0 = n_col[2]; d0 = n_done;
        pulse_clr(2'd2);
        wait_done(9000, "clr_done_seen");
        ticks(5);
        chk("clr_writes", 32'(n_wr - w0), 32'd8180);
        chk("clr_col2", 32'(n_col[2] - c0), 32'd8180);
        chk("clr_done_once", 32'(n_done - d0), 32'd1);
        chk("clr_no_bg", 32'(bgq.size() - q0), 32'd0);
        chk("clr_busy_after", 32'(bus.busy), 32'd0);

        // host write inside a clear
        c0 = n_col[2]; h0 = n_h100; a0 = n_ack;
        pulse_clr(2'd2);
        ticks(100);
        host_fixed = 1'b1; host_faddr = 13'h0100; host_fcol = 2'd1; host_left = 1;
        wait_done(9000, "clr_host_done_seen");
        ticks(5);
        chk("host_in_clr_write", 32'(n_h100 - h0), 32'd1);
        chk("host_in_clr_ack", 32'(n_ack - a0), 32'd1);
        chk("clr_host_col2", 32'(n_col[2] - c0), 32'd8180);

        // host write into the protected background area
        w0 = n_wr; a0 = n_ack; e0 = n_err;
        host_faddr = 13'h1FF8; host_fcol = 2'd3; host_left = 1;
        ticks(10);
        chk("drop_ack", 32'(n_ack - a0), 32'd1);
        chk("drop_err", 32'(n_err - e0), 32'd1);
        chk("drop_no_write", 32'(n_wr - w0), 32'd0);
        host_fixed = 1'b0;

        // two background requests during a clear: last one wins
        q0 = bgq.size();
        pulse_clr(2'd0);
        ticks(50);
        pulse_bg(24'h112233);
        ticks(20);
        pulse_bg(24'h445566);
        wait_done(9000, "clr_bg_done_seen");
        ticks(20);
        chk("bg_last_count", 32'(bgq.size() - q0), 32'd12);
        for (int i = 0; i < 12 && q0 + i < bgq.size(); i++)
            chk("bg_last_data", 32'(bgq[q0 + i][1:0]), 32'(exp_44[i]));

        // reset in the middle of a clear, with a coincident request
        pulse_clr(2'd3);
        c = 0;
        while (!(last_addr == 13'h0800 && !bus.fb_ie) && c < 3000) begin tick(); c++; end
        chk("reach_0800", 32'(last_addr), 32'h0800);
        q0 = bgq.size();
        rst = 1'b1; bus.bg_req = 1'b1; bus.bg_colour = 24'h123456;
        tick();
        rst = 1'b0; bus.bg_req = 1'b0;
        chk("midrst_fb_ie", 32'(bus.fb_ie), 32'd1);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        ticks(4);
        chk("midrst_req_dropped", 32'(bus.busy), 32'd0);
        chk("midrst_no_bg", 32'(bgq.size() - q0), 32'd0);
        w0 = n_wr;
        pulse_clr(2'd1);
        c = 0;
        while (n_wr == w0 && c < 10) begin tick(); c++; end
        chk("restart_addr", 32'(last_addr), 32'd0);
        wait_done(9000, "restart_done_seen");

        // randomized traffic
        host_left = 1000000;
        for (int i = 0; i < 7000; i++) begin
            bus.bg_req = ($urandom_range(0, 63) == 0);
            bus.bg_colour = 24'($urandom());
            bus.clr_req = ($urandom_range(0, 255) == 0);
            bus.clr_colour = 2'($urandom());
            rst = ($urandom_range(0, 799) == 0);
            tick();
        end
        bus.bg_req = 1'b0; bus.clr_req = 1'b0; rst = 1'b0; host_left = 0;
        ticks(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
